// File: rtl/pengtimer_pkg.sv
// Shared constants and digit type for the PengTimer clock chain.
// Used by the seconds/minutes stage and by the hour stage.
package pengtimer_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int ONES_MAX     = 9;

    typedef logic [BCD_W-1:0] bcd_t;

endpackage

// File: rtl/pengtimer_bcd_mod60.sv
// Two-digit BCD modulo-60 counter (00..59).
// wrap flags the 59 -> 00 step when carrying out is enabled.
module pengtimer_bcd_mod60
    import pengtimer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic carry_en,
    output bcd_t tens_o,
    output bcd_t ones_o,
    output logic wrap
);

    localparam bcd_t ONES_TOP = bcd_t'(ONES_MAX);
    localparam bcd_t TENS_TOP = bcd_t'(SEC_TENS_MAX);

    bcd_t ones_q, ones_d;
    bcd_t tens_q, tens_d;

    // next digit values; illegal digits fall back to 0 without carrying
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (inc) begin
            if (ones_q > ONES_TOP) begin
                ones_d = '0;
            end else if (ones_q == ONES_TOP) begin
                ones_d = '0;
                if (tens_q >= TENS_TOP) begin
                    tens_d = '0;
                end else begin
                    tens_d = tens_q + 1'b1;
                end
            end else begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    assign wrap = inc & carry_en
                & (ones_q == ONES_TOP)
                & (tens_q == TENS_TOP);

    assign tens_o = tens_q;
    assign ones_o = ones_q;

    // digit registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

endmodule

// File: rtl/pengtimer_min_sec.sv
// Seconds/minutes stage: 1 Hz prescaler, mm:ss BCD count, hour carry.
// Optional manual set mode when PENGTIMER_TIME_SET_EN is defined.
module pengtimer_min_sec
    import pengtimer_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
`ifdef PENGTIMER_TIME_SET_EN
    input  logic set_mode,
    input  logic inc_min,
    input  logic inc_sec,
`endif
    output bcd_t sec_q1,
    output bcd_t sec_q0,
    output bcd_t min_q1,
    output bcd_t min_q0,
    output logic sec_tick,
    output logic hour_inc
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic tick;
    logic tick_q;
    logic hinc_q;
    logic setm;
    logic set_sec;
    logic set_min;
    logic carry_en;
    logic sec_inc;
    logic sec_wrap;
    logic min_inc;
    logic min_wrap;

`ifdef PENGTIMER_TIME_SET_EN
    assign setm    = set_mode;
    assign set_sec = set_mode & inc_sec;
    assign set_min = set_mode & inc_min;
`else
    assign setm    = 1'b0;
    assign set_sec = 1'b0;
    assign set_min = 1'b0;
`endif

    // prescaler next state; set mode parks it at zero
    always_comb begin
        div_d = div_q;
        tick  = 1'b0;
        if (setm) begin
            div_d = '0;
        end else if (run) begin
            if (div_q == DIV_MAX) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    assign carry_en = ~setm;
    assign sec_inc  = tick | set_sec;
    assign min_inc  = sec_wrap | set_min;

    pengtimer_bcd_mod60 u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_inc),
        .carry_en (carry_en),
        .tens_o   (sec_q1),
        .ones_o   (sec_q0),
        .wrap     (sec_wrap)
    );

    pengtimer_bcd_mod60 u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (min_inc),
        .carry_en (carry_en),
        .tens_o   (min_q1),
        .ones_o   (min_q0),
        .wrap     (min_wrap)
    );

    // prescaler and output pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            hinc_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick;
            hinc_q <= min_wrap;
        end
    end

    assign sec_tick = tick_q;
    assign hour_inc = hinc_q;

endmodule

// File: tb/tb_pengtimer_min_sec.sv
// Scoreboard bench for pengtimer_min_sec with CLK_DIV = 4.
// Expected ticks are queued by the stimulus and checked by a monitor.
module tb_pengtimer_min_sec;

    logic clk = 1'b0;
    logic rst;
    logic run;
    logic set_mode;
    logic inc_min;
    logic inc_sec;
    logic [3:0] sec_q1, sec_q0, min_q1, min_q0;
    logic sec_tick;
    logic hour_inc;
    logic [15:0] disp;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int kk = 0;

    typedef struct {
        int k;
        int due;
    } exp_t;

    exp_t sbq[$];

    pengtimer_min_sec #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
`ifdef PENGTIMER_TIME_SET_EN
        .set_mode (set_mode),
        .inc_min  (inc_min),
        .inc_sec  (inc_sec),
`endif
        .sec_q1   (sec_q1),
        .sec_q0   (sec_q0),
        .min_q1   (min_q1),
        .min_q0   (min_q0),
        .sec_tick (sec_tick),
        .hour_inc (hour_inc)
    );

    assign disp = {min_q1, min_q0, sec_q1, sec_q0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] bcd4(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at cyc %0d", nm, act, exp, cyc);
        end
    endfunction

    task automatic push_run(input int n, input int first_due);
        for (int i = 0; i < n; i++) begin
            kk++;
            sbq.push_back('{k: kk, due: first_due + 4 * i});
        end
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (sbq.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout left=%0d", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic pulse(input int n, input logic do_sec, input logic do_min);
        for (int i = 0; i < n; i++) begin
            inc_sec = do_sec;
            inc_min = do_min;
            @(negedge clk);
            inc_sec = 1'b0;
            inc_min = 1'b0;
            @(negedge clk);
        end
    endtask

    exp_t mon_e;
    int mon_m;
    int mon_s;

    always @(negedge clk) begin
        if (sec_tick) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tick disp=%h at cyc %0d", disp, cyc);
            end else begin
                mon_e = sbq.pop_front();
                mon_m = (mon_e.k % 3600) / 60;
                mon_s = mon_e.k % 60;
                chk("tick_cycle", cyc, mon_e.due);
                chk("tick_display", int'(disp), int'(bcd4(mon_m, mon_s)));
                chk("tick_hour_inc", int'(hour_inc),
                    (mon_e.k % 3600 == 0) ? 1 : 0);
            end
        end else if (hour_inc) begin
            total++;
            bad++;
            $display("FAIL stray_hour_inc act=1 exp=0 at cyc %0d", cyc);
        end
    end

    initial begin
        int c0;
        int d1;
        int d2;
        int pc;
        rst      = 1'b1;
        run      = 1'b1;
        set_mode = 1'b0;
        inc_min  = 1'b0;
        inc_sec  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_display", int'(disp), 0);
        chk("reset_sec_tick", int'(sec_tick), 0);
        chk("reset_hour_inc", int'(hour_inc), 0);

        rst = 1'b0;
        c0 = cyc;
        push_run(3601, c0 + 4);
        d1 = c0 + 4 * 3601;
        while (cyc < d1 + 2) @(negedge clk);
        chk("queue_after_hour", sbq.size(), 0);

        run = 1'b0;
        repeat (10) @(negedge clk);
        chk("pause_display", int'(disp), int'(bcd4(0, 1)));

        run = 1'b1;
        pc = cyc;
        push_run(1, pc + 2);
        push_run(3598, pc + 6);
        d2 = pc + 6 + 4 * 3597;
        while (cyc < d2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_hour_inc", int'(hour_inc), 0);
        chk("rst_mid_sec_tick", int'(sec_tick), 0);
        chk("rst_mid_display", int'(disp), 0);
        chk("rst_mid_queue", sbq.size(), 0);

        run = 1'b0;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_display", int'(disp), 0);

`ifdef PENGTIMER_TIME_SET_EN
        set_mode = 1'b1;
        run      = 1'b1;
        pulse(61, 1'b1, 1'b0);
        chk("set_sec61", int'(disp), int'(bcd4(0, 1)));
        pulse(59, 1'b0, 1'b1);
        pulse(58, 1'b1, 1'b0);
        chk("set_5959", int'(disp), int'(bcd4(59, 59)));
        inc_sec = 1'b1;
        inc_min = 1'b1;
        @(negedge clk);
        inc_sec = 1'b0;
        inc_min = 1'b0;
        chk("set_both_display", int'(disp), 0);
        chk("set_both_hour_inc", int'(hour_inc), 0);
        @(negedge clk);
        set_mode = 1'b0;
        kk = 0;
        pc = cyc;
        push_run(1, pc + 4);
        drain(20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
